// File: rtl/wr_fifo_burst_arbiter_if.sv
// Bundle between the per-channel write FIFOs, the arbiter and the DDR write master.
// No latency: plain wires grouped for port connection.
// Backpressure travels on m_awready / m_wready, and on ch_rd_vld for FIFO starvation.
interface wr_fifo_burst_arbiter_if #(
  parameter int N_CH = 4,
  parameter int DW   = 32,
  parameter int AW   = 28
);
  logic [N_CH*DW-1:0] ch_rd_data;
  logic [N_CH-1:0]    ch_rd_vld;
  logic [N_CH-1:0]    ch_rd_en;
  logic [N_CH*AW-1:0] ch_base_addr;
  logic [N_CH-1:0]    ch_addr_rst;
  logic [AW-1:0]      m_awaddr;
  logic [7:0]         m_awlen;
  logic               m_awvalid;
  logic               m_awready;
  logic [DW-1:0]      m_wdata;
  logic               m_wvalid;
  logic               m_wready;
  logic               m_wlast;

  // Arbiter side
  modport master (
    input  ch_rd_data, ch_rd_vld, ch_base_addr, ch_addr_rst, m_awready, m_wready,
    output ch_rd_en, m_awaddr, m_awlen, m_awvalid, m_wdata, m_wvalid, m_wlast
  );

  // FIFO / write-master side
  modport slave (
    output ch_rd_data, ch_rd_vld, ch_base_addr, ch_addr_rst, m_awready, m_wready,
    input  ch_rd_en, m_awaddr, m_awlen, m_awvalid, m_wdata, m_wvalid, m_wlast
  );
endinterface

// File: rtl/wr_fifo_burst_arbiter.sv
// Round-robin arbiter draining fixed-length bursts from N_CH FIFOs onto one AW/W write port.
// Latency: a request seen in IDLE gives m_awvalid on the next cycle; W beats pass through combinationally.
// Backpressure: m_wready feeds straight through to the granted FIFO pop. A starving FIFO only inserts gaps; a burst is never aborted.
module wr_fifo_burst_arbiter #(
  parameter int N_CH        = 4,
  parameter int DW          = 32,
  parameter int AW          = 28,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BEATS = 262144
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  wr_fifo_burst_arbiter_if.master bus,
  output logic [2:0]             grant_id,
  output logic                   busy
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BSH   = $clog2(DW / 8);
  localparam int OFF_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t          state;
  logic [CH_W-1:0] g_q;
  logic [CH_W-1:0] win;
  logic [CH_W-1:0] cand;
  logic            win_found;
  logic [OFF_W-1:0] offset [N_CH];
  logic [N_CH-1:0] pend;
  logic [7:0]      beat_cnt;
  logic [AW-1:0]   awaddr_q;
  logic            awvalid_q;
  logic [DW-1:0]   ch_data [N_CH];
  logic [AW-1:0]   ch_base [N_CH];
  logic [OFF_W-1:0] win_off;
  logic [OFF_W-1:0] off_nxt;
  logic [AW-1:0]   awaddr_nxt;
  logic            beat_fire;
  logic            last_beat;
  logic [N_CH-1:0] rd_en;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = bus.ch_rd_data[i*DW +: DW];
    assign ch_base[i] = bus.ch_base_addr[i*AW +: AW];
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    win       = g_q;
    win_found = 1'b0;
    cand      = g_q;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CH_W'((int'(g_q) + k) % N_CH);
      if (!win_found && bus.ch_rd_vld[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  // A restart pulse arriving on the grant edge already counts: the winner starts at its base
  assign win_off    = bus.ch_addr_rst[win] ? '0 : offset[win];
  assign awaddr_nxt = ch_base[win] + (AW'(win_off) << BSH);
  assign off_nxt    = (int'(offset[g_q]) + BURST_LEN == FRAME_BEATS) ? '0
                                                                      : offset[g_q] + OFF_W'(BURST_LEN);

  assign beat_fire = (state == DATA) && bus.ch_rd_vld[g_q] && bus.m_wready;
  assign last_beat = (state == DATA) && (beat_cnt == LAST_BEAT);

  // Only the granted channel is popped, and only while the write master is ready
  always_comb begin
    rd_en = '0;
    if (state == DATA) rd_en[g_q] = bus.m_wready;
  end

  assign bus.ch_rd_en  = rd_en;
  assign bus.m_wvalid  = (state == DATA) && bus.ch_rd_vld[g_q];
  assign bus.m_wdata   = (state == DATA) ? ch_data[g_q] : '0;
  assign bus.m_wlast   = last_beat;
  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_awlen   = LAST_BEAT;
  assign grant_id      = 3'(g_q);
  assign busy          = (state != IDLE);

  // Arbitration FSM with per-channel frame offsets and deferred restarts
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state     <= IDLE;
      g_q       <= CH_W'(N_CH - 1);
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      beat_cnt  <= '0;
      pend      <= '0;
      for (int i = 0; i < N_CH; i++) offset[i] <= '0;
    end else begin
      // Restart requests: immediate for idle channels, deferred for the one mid-burst
      for (int i = 0; i < N_CH; i++) begin
        if (bus.ch_addr_rst[i]) begin
          if (state != IDLE && CH_W'(i) == g_q) pend[i] <= 1'b1;
          else                                  offset[i] <= '0;
        end
      end
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= ADDR;
            g_q       <= win;
            awaddr_q  <= awaddr_nxt;
            awvalid_q <= 1'b1;
          end
        end
        ADDR: begin
          if (bus.m_awready) begin
            awvalid_q <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat_fire) begin
            if (last_beat) begin
              state       <= IDLE;
              offset[g_q] <= (pend[g_q] || bus.ch_addr_rst[g_q]) ? '0 : off_nxt;
              pend[g_q]   <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wr_fifo_burst_arbiter.sv
// Bench for wr_fifo_burst_arbiter: directed burst table, corner-case sequences, randomized traffic.
// A transaction-level model predicts grants, addresses, beats and data each cycle.
// Inputs change 1 time unit after rd_clk rises; outputs are sampled on the falling edge.
module tb_wr_fifo_burst_arbiter;
  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int AW   = 28;
  localparam int BL   = 16;
  localparam int FB   = 64;

  logic       rd_clk = 1'b0;
  logic       rd_rst = 1'b1;
  logic [2:0] grant_id;
  logic       busy;

  wr_fifo_burst_arbiter_if #(.N_CH(N_CH), .DW(DW), .AW(AW)) bus ();

  wr_fifo_burst_arbiter #(
    .N_CH(N_CH), .DW(DW), .AW(AW), .BURST_LEN(BL), .FRAME_BEATS(FB)
  ) dut (
    .rd_clk   (rd_clk),
    .rd_rst   (rd_rst),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int vecs  = 0;
  int fails = 0;

  // FIFO model: each channel emits {channel, A5, sequence number}; pops advance the sequence
  logic [15:0]   seq  [N_CH] = '{default: 16'h0};
  logic [AW-1:0] base [N_CH] = '{28'h0001000, 28'h0200000, 28'h0100000, 28'hFFFFFC0};

  always_comb begin
    bus.ch_rd_data   = '0;
    bus.ch_base_addr = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.ch_rd_data[i*DW +: DW]   = {8'(i), 8'hA5, seq[i]};
      bus.ch_base_addr[i*AW +: AW] = base[i];
    end
  end

  always @(posedge rd_clk) begin
    for (int i = 0; i < N_CH; i++)
      if (bus.ch_rd_vld[i] && bus.ch_rd_en[i]) seq[i] <= seq[i] + 16'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            mdl_open;
  bit            mdl_awdone;
  int            mdl_ch;
  int            mdl_last;
  int            mdl_beats;
  logic [AW-1:0] mdl_addr;
  int            bursts [N_CH];   // bursts completed since the last address restart
  bit            rst_pend [N_CH];
  int            pops [N_CH] = '{default: 0};

  function automatic logic [AW-1:0] addr_of(input int ch);
    int beat_off;
    beat_off = (bursts[ch] * BL) % FB;
    return base[ch] + AW'(beat_off * (DW / 8));
  endfunction

  initial begin
    forever begin
      @(negedge rd_clk);
      if (rd_rst) begin
        chk("rst_awvalid", 32'(bus.m_awvalid), 0);
        chk("rst_wvalid",  32'(bus.m_wvalid), 0);
        chk("rst_wlast",   32'(bus.m_wlast), 0);
        chk("rst_rd_en",   32'(bus.ch_rd_en), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_awaddr",  32'(bus.m_awaddr), 0);
        chk("rst_wdata",   32'(bus.m_wdata), 0);
        chk("rst_grant",   32'(grant_id), N_CH - 1);
        chk("rst_awlen",   32'(bus.m_awlen), BL - 1);
        mdl_open = 0;
        mdl_awdone = 0;
        mdl_last = N_CH - 1;
        mdl_ch = 0;
        mdl_beats = 0;
        for (int i = 0; i < N_CH; i++) begin
          bursts[i] = 0;
          rst_pend[i] = 0;
        end
      end else begin
        bit aw_ph, w_ph, exp_wv;
        logic [N_CH-1:0] exp_en;
        aw_ph  = mdl_open && !mdl_awdone;
        w_ph   = mdl_open && mdl_awdone;
        exp_en = (w_ph && bus.m_wready) ? N_CH'(1 << mdl_ch) : '0;
        exp_wv = w_ph && bus.ch_rd_vld[mdl_ch];
        chk("busy",    32'(busy), 32'(mdl_open));
        chk("grant",   32'(grant_id), mdl_last);
        chk("awvalid", 32'(bus.m_awvalid), 32'(aw_ph));
        chk("awlen",   32'(bus.m_awlen), BL - 1);
        if (aw_ph) chk("awaddr", 32'(bus.m_awaddr), 32'(mdl_addr));
        chk("rd_en",   32'(bus.ch_rd_en), 32'(exp_en));
        chk("wvalid",  32'(bus.m_wvalid), 32'(exp_wv));
        chk("wlast",   32'(bus.m_wlast), 32'(w_ph && mdl_beats == BL - 1));
        if (exp_wv) chk("wdata", bus.m_wdata, {8'(mdl_ch), 8'hA5, 16'(pops[mdl_ch])});
        // predict the effect of the coming rising edge
        if (!mdl_open) begin
          for (int i = 0; i < N_CH; i++) if (bus.ch_addr_rst[i]) bursts[i] = 0;
          for (int k = 1; k <= N_CH && !mdl_open; k++) begin
            int c;
            c = (mdl_last + k) % N_CH;
            if (bus.ch_rd_vld[c]) begin
              mdl_open = 1;
              mdl_awdone = 0;
              mdl_ch = c;
              mdl_last = c;
              mdl_beats = 0;
              mdl_addr = addr_of(c);
            end
          end
        end else begin
          for (int i = 0; i < N_CH; i++)
            if (bus.ch_addr_rst[i]) begin
              if (i == mdl_ch) rst_pend[i] = 1;
              else             bursts[i] = 0;
            end
          if (!mdl_awdone) begin
            if (bus.m_awready) mdl_awdone = 1;
          end else if (bus.ch_rd_vld[mdl_ch] && bus.m_wready) begin
            pops[mdl_ch]++;
            if (mdl_beats == BL - 1) begin
              bursts[mdl_ch] = rst_pend[mdl_ch] ? 0 : bursts[mdl_ch] + 1;
              rst_pend[mdl_ch] = 0;
              mdl_open = 0;
            end else begin
              mdl_beats++;
            end
          end
        end
      end
    end
  end

  // ---------------- directed burst driver ----------------
  // Entered and left just after a rising edge, so the caller's mask is what an idle arbiter sees.
  task automatic run_burst(input logic [3:0] mask, input int ch, input logic [AW-1:0] addr,
                           input bit rnd, input int starve_at, input int pulse_at,
                           input logic [3:0] pulse_mask, input int reset_at);
    int beats = 0;
    int starve_left = 0;
    bit got = 0, done = 0, starved = 0, pulsed = 0;
    logic [15:0] s0;
    bus.ch_rd_vld   = mask;
    bus.m_awready   = 1'b1;
    bus.m_wready    = 1'b1;
    bus.ch_addr_rst = '0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge rd_clk);
      if (bus.m_awvalid) got = 1;
    end
    chk("aw_seen", 32'(got), 1);
    if (!got) begin
      @(posedge rd_clk); #1;
      return;
    end
    chk("aw_grant", 32'(grant_id), ch);
    chk("aw_addr",  32'(bus.m_awaddr), 32'(addr));
    s0 = seq[ch];
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge rd_clk); #1;
      if (reset_at > 0 && beats == reset_at) begin
        #2 rd_rst = 1'b1;
        #1;
        chk("arst_wvalid",  32'(bus.m_wvalid), 0);
        chk("arst_awvalid", 32'(bus.m_awvalid), 0);
        chk("arst_rd_en",   32'(bus.ch_rd_en), 0);
        chk("arst_busy",    32'(busy), 0);
        chk("arst_pops",    32'(16'(seq[ch] - s0)), reset_at);
        repeat (2) @(posedge rd_clk);
        #1 rd_rst = 1'b0;
        return;
      end
      bus.m_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!starved && starve_at > 0 && beats == starve_at) begin
        starved = 1;
        starve_left = 5;
      end
      if (starve_left > 0) begin
        bus.ch_rd_vld = mask & ~(4'b1 << ch);
        starve_left--;
      end else begin
        bus.ch_rd_vld = mask;
      end
      if (pulse_at > 0 && !pulsed && beats == pulse_at - 1) begin
        bus.ch_addr_rst = pulse_mask;
        pulsed = 1;
      end else begin
        bus.ch_addr_rst = '0;
      end
      @(negedge rd_clk);
      if (bus.m_wvalid && bus.m_wready) begin
        beats++;
        if (bus.m_wlast) begin
          done = 1;
          chk("last_beat_no", beats, BL);
        end
      end
    end
    chk("burst_done", 32'(done), 1);
    @(posedge rd_clk); #1;
    bus.ch_addr_rst = '0;
    chk("pops", 32'(16'(seq[ch] - s0)), BL);
  endtask

  typedef struct {
    logic [3:0]    mask;
    int            ch;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // {requesting channels, expected winner, expected burst address}
    tbl[0]  = '{4'b1111, 0, 28'h0001000};
    tbl[1]  = '{4'b1111, 1, 28'h0200000};
    tbl[2]  = '{4'b1111, 2, 28'h0100000};
    tbl[3]  = '{4'b1111, 3, 28'hFFFFFC0};
    tbl[4]  = '{4'b1111, 0, 28'h0001040};
    tbl[5]  = '{4'b0100, 2, 28'h0100040};
    tbl[6]  = '{4'b0100, 2, 28'h0100080};
    tbl[7]  = '{4'b1000, 3, 28'h0000000};  // base + 0x40 wraps modulo 2^28
    tbl[8]  = '{4'b0010, 1, 28'h0200040};
    tbl[9]  = '{4'b0010, 1, 28'h0200080};
    tbl[10] = '{4'b0010, 1, 28'h02000C0};
    tbl[11] = '{4'b0010, 1, 28'h0200000};  // frame of 64 beats wraps back to base
    tbl[12] = '{4'b1001, 3, 28'h0000040};
    tbl[13] = '{4'b1001, 0, 28'h0001080};

    bus.ch_rd_vld   = 4'b1111;
    bus.ch_addr_rst = '0;
    bus.m_awready   = 1'b1;
    bus.m_wready    = 1'b1;
    rd_rst          = 1'b1;
    repeat (3) @(posedge rd_clk);
    #1 rd_rst = 1'b0;

    for (int r = 0; r < 14; r++)
      run_burst(tbl[r].mask, tbl[r].ch, tbl[r].addr, 0, 0, 0, 4'b0, 0);

    // backpressure with random wready and a 5-cycle starvation gap
    run_burst(4'b0001, 0, 28'h00010C0, 1, 6, 0, 4'b0, 0);
    // restart pulse mid-burst on the granted ch1 and the idle ch2
    run_burst(4'b0010, 1, 28'h0200040, 0, 0, 8, 4'b0110, 0);
    run_burst(4'b0010, 1, 28'h0200000, 0, 0, 0, 4'b0, 0);
    run_burst(4'b0100, 2, 28'h0100000, 0, 0, 0, 4'b0, 0);
    // asynchronous reset after beat 5, then restart at ch0 offset 0
    run_burst(4'b0001, 0, 28'h0001000, 0, 0, 0, 4'b0, 0);
    run_burst(4'b0001, 0, 28'h0001040, 0, 0, 0, 4'b0, 5);
    run_burst(4'b1111, 0, 28'h0001000, 0, 0, 0, 4'b0, 0);

    // randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        bus.ch_rd_vld[i]   = ($urandom_range(0, 99) < 70);
        bus.ch_addr_rst[i] = ($urandom_range(0, 99) < 2);
      end
      bus.m_awready = ($urandom_range(0, 99) < 60);
      bus.m_wready  = ($urandom_range(0, 99) < 70);
      @(posedge rd_clk); #1;
    end
    for (int i = 0; i < N_CH; i++) chk("total_pops", 32'(seq[i]), 32'(16'(pops[i])));
    bus.ch_rd_vld   = '0;
    bus.ch_addr_rst = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
